// File: rtl/spectrum_pkg.sv
// Shared constants for the spectrum display path: default geometry,
// magnitude width and the three palette colours.
package spectrum_pkg;

  localparam int DEF_MAG_W      = 16;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_BAR_SHIFT  = 2;
  localparam int DEF_N_BINS     = DEF_H_ACTIVE >> DEF_BAR_SHIFT;
  localparam int DEF_MAG_SHIFT  = 1;
  localparam int DEF_GRID_SHIFT = 6;
  localparam int COORD_W        = 14;

  typedef logic [23:0] rgb_t;

  localparam rgb_t DEF_BAR_COLOR  = 24'h00FF00;
  localparam rgb_t DEF_BG_COLOR   = 24'h101010;
  localparam rgb_t DEF_GRID_COLOR = 24'h404040;

endpackage

// File: rtl/spectrum_renderer_if.sv
// Bin stream into the renderer: one magnitude per beat, bin 0 first,
// beat taken when valid && ready.
interface spectrum_renderer_if
  import spectrum_pkg::*;
#(
  parameter int MAG_W = DEF_MAG_W
) ();
  logic             valid;
  logic [MAG_W-1:0] data;
  logic             last;
  logic             ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/spectrum_bank_ram.sv
// Simple dual-port bin memory. Address MSB selects the bank, so the depth
// is rounded up to a power of two per bank. Read data lands one cycle
// after the address.
module spectrum_bank_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Synchronous write and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/spectrum_renderer.sv
// Spectrum bar renderer: double-buffered bin store fed by a valid/ready
// stream, bank swap at the start of vertical blanking, and a two-stage
// pixel pipeline (RAM read, then colour select) ahead of the HDMI encoder.
module spectrum_renderer
  import spectrum_pkg::*;
#(
  parameter int   N_BINS     = DEF_N_BINS,
  parameter int   MAG_W      = DEF_MAG_W,
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   BAR_SHIFT  = DEF_BAR_SHIFT,
  parameter int   MAG_SHIFT  = DEF_MAG_SHIFT,
  parameter int   GRID_SHIFT = DEF_GRID_SHIFT,
  parameter rgb_t BAR_COLOR  = DEF_BAR_COLOR,
  parameter rgb_t BG_COLOR   = DEF_BG_COLOR,
  parameter rgb_t GRID_COLOR = DEF_GRID_COLOR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  i_sx,
  input  logic [COORD_W-1:0]  i_sy,
  output rgb_t                o_rgb,
  spectrum_renderer_if.slave  bin_if
);
  localparam int IDX_W  = $clog2(N_BINS);
  localparam int CNT_W  = $clog2(N_BINS + 1);
  localparam int HT_W   = $clog2(V_ACTIVE) + 1;
  localparam int ADDR_W = IDX_W + 1;

  localparam logic [COORD_W-1:0] H_LIM    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM    = COORD_W'(V_ACTIVE);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_BINS - 1);
  localparam logic [HT_W-1:0]    V_HT     = HT_W'(V_ACTIVE);
  localparam logic [MAG_W-1:0]   V_MAG    = MAG_W'(V_ACTIVE);

  // Write controller / bank state
  logic                  disp_bank_reg;
  logic [1:0][CNT_W-1:0] count_reg;
  logic [IDX_W-1:0]      wr_idx_reg;
  logic                  complete_reg;
  logic                  ready_reg;

  logic wr_bank, accept, beat_last, swap_pt, do_swap;

  assign wr_bank   = ~disp_bank_reg;
  assign accept    = bin_if.valid & ready_reg;
  assign beat_last = bin_if.last | (wr_idx_reg == LAST_IDX);
  assign swap_pt   = (i_sx == '0) && (i_sy == V_LIM);
  // Only registered completion counts, so a last beat landing on the swap
  // cycle itself waits a full frame.
  assign do_swap   = swap_pt & complete_reg;
  assign bin_if.ready = ready_reg;

  // Bank swap at vblank start, otherwise accept beats into the write bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_bank_reg <= 1'b0;
      count_reg     <= '0;
      wr_idx_reg    <= '0;
      complete_reg  <= 1'b0;
      ready_reg     <= 1'b1;
    end else if (do_swap) begin
      disp_bank_reg            <= wr_bank;
      count_reg[disp_bank_reg] <= '0;
      wr_idx_reg               <= '0;
      complete_reg             <= 1'b0;
      ready_reg                <= 1'b1;
    end else if (accept) begin
      if (beat_last) begin
        complete_reg       <= 1'b1;
        ready_reg          <= 1'b0;
        count_reg[wr_bank] <= CNT_W'(wr_idx_reg) + CNT_W'(1);
      end else begin
        wr_idx_reg <= wr_idx_reg + IDX_W'(1);
      end
    end
  end

  // Stage 0: bar index from the column, RAM read from the display bank.
  logic [COORD_W-1:0] bin_full;
  logic [ADDR_W-1:0]  rd_addr;
  logic [MAG_W-1:0]   rd_data;
  logic               in_count;

  assign bin_full = i_sx >> BAR_SHIFT;
  assign rd_addr  = {disp_bank_reg, bin_full[IDX_W-1:0]};
  assign in_count = COORD_W'(count_reg[disp_bank_reg]) > bin_full;

  spectrum_bank_ram #(
    .DATA_W (MAG_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (accept & ~do_swap),
    .wr_addr ({wr_bank, wr_idx_reg}),
    .wr_data (bin_if.data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  logic [COORD_W-1:0] sx0_reg, sy0_reg;
  logic               in_count0_reg;

  // Stage 0 registers: coordinates and whether the bin holds fresh data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sx0_reg       <= '0;
      sy0_reg       <= '0;
      in_count0_reg <= 1'b0;
    end else begin
      sx0_reg       <= i_sx;
      sy0_reg       <= i_sy;
      in_count0_reg <= in_count;
    end
  end

  // Stage 1: bar height, clamped to the screen, zero for unwritten bins.
  logic [MAG_W-1:0] mag_ht;
  logic [HT_W-1:0]  bar_ht;
  logic             in_bar;

  always_comb begin
    mag_ht = rd_data >> MAG_SHIFT;
    bar_ht = '0;
    if (in_count0_reg) bar_ht = (mag_ht > V_MAG) ? V_HT : HT_W'(mag_ht);
    in_bar = sy0_reg[HT_W-1:0] >= (V_HT - bar_ht);
  end

  rgb_t rgb_next, o_rgb_reg;

  // Stage 1 colour priority: blanking, gap column, bar, grid, background.
  always_comb begin
    rgb_next = BG_COLOR;
    if (sx0_reg >= H_LIM || sy0_reg >= V_LIM)  rgb_next = '0;
    else if (&sx0_reg[BAR_SHIFT-1:0])          rgb_next = BG_COLOR;
    else if (in_bar)                           rgb_next = BAR_COLOR;
    else if (sy0_reg[GRID_SHIFT-1:0] == '0)    rgb_next = GRID_COLOR;
  end

  // Output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_rgb_reg <= '0;
    else        o_rgb_reg <= rgb_next;
  end

  assign o_rgb = o_rgb_reg;
endmodule

// File: tb/tb_spectrum_renderer.sv
// Randomised scoreboard bench for spectrum_renderer: a frame-level model of
// the displayed spectrum predicts every queried pixel; a monitor compares
// o_rgb two cycles later.
module tb_spectrum_renderer;
  localparam int HA = 640;
  localparam int VA = 480;
  localparam int NB = 160;
  localparam logic [23:0] C_BAR  = 24'h00FF00;
  localparam logic [23:0] C_BG   = 24'h101010;
  localparam logic [23:0] C_GRID = 24'h404040;

  typedef struct {
    int          sx;
    int          sy;
    logic [23:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] i_sx = '0;
  logic [13:0] i_sy = '0;
  logic [23:0] o_rgb;

  spectrum_renderer_if #(.MAG_W(16)) bin_if ();

  spectrum_renderer dut (
    .clk    (clk),
    .reset  (reset),
    .i_sx   (i_sx),
    .i_sy   (i_sy),
    .o_rgb  (o_rgb),
    .bin_if (bin_if)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_cur = 1'b0;
  exp_t exp_q[$];

  // Reference model: what is on screen and what is being collected.
  int disp_mag[NB];
  int disp_cnt = 0;
  int pend_mag[NB];
  int pend_cnt = 0;
  int m_widx = 0;
  bit m_ready = 1'b1;
  bit m_complete = 1'b0;
  int ld_mag[NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input int sx, input int sy);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (sx=%0d sy=%0d): got %h, expected %h", name, sx, sy, act, exp);
  endtask

  function automatic logic [23:0] expect_rgb(input int sx, input int sy);
    int h;
    int bin;
    if (sx >= HA || sy >= VA) return 24'h0;
    if (sx % 4 == 3) return C_BG;
    bin = sx / 4;
    h = (bin < disp_cnt) ? disp_mag[bin] / 2 : 0;
    if (h > VA) h = VA;
    if (sy >= VA - h) return C_BAR;
    if (sy % 64 == 0) return C_GRID;
    return C_BG;
  endfunction

  function automatic void model_reset();
    disp_cnt = 0;
    pend_cnt = 0;
    m_widx = 0;
    m_ready = 1'b1;
    m_complete = 1'b0;
  endfunction

  function automatic void model_step(input int sx, input int sy, input bit v, input int d,
                                     input bit l);
    if (sx == 0 && sy == VA && m_complete) begin
      disp_mag = pend_mag;
      disp_cnt = pend_cnt;
      pend_cnt = 0;
      m_widx = 0;
      m_complete = 1'b0;
      m_ready = 1'b1;
    end else if (v && m_ready) begin
      pend_mag[m_widx] = d;
      m_widx++;
      if (l || m_widx == NB) begin
        m_complete = 1'b1;
        m_ready = 1'b0;
        pend_cnt = m_widx;
      end
    end
  endfunction

  // One clock of stimulus: drive pixel and bin beat, predict, advance model.
  task automatic cycle(input int sx, input int sy, input bit chk, input bit v, input int d,
                       input bit l);
    exp_t e;
    @(negedge clk);
    i_sx = 14'(sx);
    i_sy = 14'(sy);
    bin_if.valid = v;
    bin_if.data = 16'(d);
    bin_if.last = l;
    check("bin_ready", {31'b0, bin_if.ready}, {31'b0, m_ready}, sx, sy);
    chk_cur = chk;
    if (chk) begin
      e.sx = sx;
      e.sy = sy;
      e.rgb = expect_rgb(sx, sy);
      exp_q.push_back(e);
    end
    if (reset) model_step(sx, sy, v, d, l);
  endtask

  task automatic rnd_xy(output int sx, output int sy);
    sx = $urandom_range(0, 659);
    sy = $urandom_range(0, 499);
    if (sx == 0 && sy == VA) sy = VA + 1;
  endtask

  task automatic query(input int n);
    int sx, sy;
    for (int i = 0; i < n; i++) begin
      rnd_xy(sx, sy);
      cycle(sx, sy, 1'b1, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic spot(input int sx, input int sy);
    cycle(sx, sy, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic swap_point();
    cycle(0, VA, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(700, 500, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Stream n beats from ld_mag with random idle gaps; last flag on beat
  // last_at (-1: none). With race set, the last beat sits on the swap point.
  task automatic load(input int n, input int last_at, input bit race);
    int sx, sy;
    $display("load: %0d beats, last flag on beat %0d, race=%0d", n, last_at, race);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) query(1);
      rnd_xy(sx, sy);
      if (race && i == last_at) begin
        sx = 0;
        sy = VA;
      end
      cycle(sx, sy, 1'b1, 1'b1, ld_mag[i], i == last_at);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++)
      ld_mag[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 1023));
  endtask

  task automatic do_reset();
    int sx, sy;
    drain();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_cur = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd_xy(sx, sy);
      cycle(sx, sy, 1'b0, 1'b1, 5, 1'b0);
      check("rgb_in_reset", {8'b0, o_rgb}, 32'h0, sx, sy);
    end
    @(negedge clk);
    reset = 1'b1;
    bin_if.valid = 1'b0;
    $display("reset: released");
  endtask

  // Monitor: each output sample pairs with the query captured one edge earlier.
  initial begin
    bit   pend = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd0, 32'd1, -1, -1);
        end else begin
          e = exp_q.pop_front();
          check("rgb", {8'b0, o_rgb}, {8'b0, e.rgb}, e.sx, e.sy);
        end
      end
      pend = chk_cur;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bin_if.valid = 1'b0;
    bin_if.data = '0;
    bin_if.last = 1'b0;
    for (int i = 0; i < NB; i++) begin
      disp_mag[i] = 0;
      pend_mag[i] = 0;
    end

    // Reset and empty display
    do_reset();
    spot(5, 0); spot(5, 64); spot(5, 448); spot(5, 1); spot(7, 0); spot(639, 479);
    query(200);

    // Uniform load
    for (int i = 0; i < NB; i++) ld_mag[i] = 16'h0100;
    load(NB, NB - 1, 1'b0);
    query(20);
    swap_point();
    spot(2, 400); spot(3, 400); spot(2, 351); spot(2, 352); spot(640, 10);
    query(300);

    // Short spectrum, then ignored beats while ready is low
    fill_random();
    load(10, 9, 1'b0);
    for (int i = 0; i < 4; i++) cycle(700, 10, 1'b1, 1'b1, int'($urandom_range(0, 65535)), 1'b0);
    query(20);
    swap_point();
    spot(40, 479); spot(100, 479); spot(36, 479);
    query(300);

    // Clamp with implicit last
    fill_random();
    ld_mag[5] = 16'hFFFF;
    load(NB, -1, 1'b0);
    swap_point();
    spot(20, 0); spot(20, 64); spot(20, 479); spot(21, 200); spot(23, 0);
    query(300);

    // Last beat on the swap cycle
    fill_random();
    load(20, 19, 1'b1);
    spot(20, 0);
    query(100);
    swap_point();
    spot(20, 0);
    query(200);

    // Reset in the middle of a spectrum, then a full load
    fill_random();
    load(50, -1, 1'b0);
    do_reset();
    spot(20, 0);
    query(100);
    fill_random();
    load(NB, NB - 1, 1'b0);
    swap_point();
    query(300);

    drain();
    check("queue_drained", exp_q.size(), 32'd0, -1, -1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
